fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control FSM for the PC-counter / program-ROM / fetch-register datapath.
- Drives the counter's increment and load strobes and the fetch register's enable, in the order fetch -> decode -> advance.
- Supports free-run and single-step operation, host-requested jumps, and a HALT opcode.
- Sits beside the fusion datapath; its strobes connect directly to En, non, load and En2.

Parameters:
- HALT_OP, 4'hF, opcode value in the fetched upper nibble that halts the sequencer
- ADDR_W, 12, PC width; must match the counter width

Ports:
- Clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  level; sampled in IDLE, begins sequencing
- step_mode  input  1  1 = execute one instruction and then return to IDLE
- resume  input  1  pulse; leaves HALT and goes to IDLE
- jump_req  input  1  sampled in DECODE; selects a load instead of an increment
- jump_addr  input  ADDR_W  PC target used when jump_req is taken
- opcode  input  4  fetch register upper nibble (Q1)
- operand  input  4  fetch register lower nibble (Q2); not decoded, passed through
- pc_en  output  1  counter increment strobe (En)
- pc_load  output  1  counter load strobe (non)
- pc_load_val  output  ADDR_W  counter load value
- fetch_en  output  1  fetch register enable (En2)
- instr_valid  output  1  one-cycle pulse; opcode/operand hold a fresh instruction
- pc_shadow  output  ADDR_W  controller copy of the PC
- busy  output  1  high in every state except IDLE and HALT
- halted  output  1  high in HALT

Behaviour:
- Reset (reset == 0, asynchronous):
  - State goes to IDLE.
  - pc_shadow, pc_load_val = 0.
  - All strobes, instr_valid, busy, halted = 0.
  - Assertion mid-instruction aborts immediately; no strobe may be issued in that cycle.
- States: IDLE, FETCH, DECODE, ADVANCE, HALT. All outputs are registered.
- IDLE: start == 1 -> FETCH.
- FETCH (1 cycle): fetch_en = 1 for exactly this cycle. The ROM is combinational on the PC, so the fetch register captures ROM[pc_shadow] at the end of the cycle. Next state: DECODE.
- DECODE (1 cycle):
  - instr_valid = 1.
  - opcode == HALT_OP -> HALT. The PC is not advanced, and the HALT check takes priority over jump_req.
  - Otherwise, latch jump_req/jump_addr and go to ADVANCE.
- ADVANCE (1 cycle):
  - If the latched jump was taken: pc_load = 1, pc_load_val = jump_addr, pc_shadow <= jump_addr.
  - Otherwise: pc_en = 1, pc_shadow <= pc_shadow + 1.
  - Next state: step_mode ? IDLE : FETCH.
- Instruction cadence in free run: one instruction per 3 cycles. Each fetch reflects the PC produced by the previous ADVANCE.
- Mutual exclusion: pc_en and pc_load are never high together. The counter gives En priority over load, so this rule must hold.
- Wrap-around: pc_shadow 4095 + 1 -> 0, matching the counter. No flag is raised.
- HALT: holds until resume == 1 -> IDLE. start is ignored while in HALT.
- Edge cases:
  - start held high with step_mode = 1: the block re-enters FETCH from IDLE on the next cycle. Step-by-step use relies on the host pulsing start.
  - start deasserted mid-run does not stop sequencing. Only HALT_OP or reset stops it.

Optional Feature:
- Macro: FETCH_BKPT_EN.
- When defined:
  - Adds input bkpt_addr[ADDR_W-1:0] and input bkpt_arm.
  - On entry to FETCH, if bkpt_arm && pc_shadow == bkpt_addr, go to HALT instead. No fetch_en is issued and the PC is unchanged.
  - resume then enters IDLE. The next start fetches the breakpoint instruction normally: the breakpoint is suppressed for one fetch.
- When undefined: the ports are absent and FETCH is never diverted.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, FETCH, DECODE, ADVANCE, HALT)
  - HALT_OP default
  - ADDR_W
- The reusable sub-module is pc_shadow_reg: a 12-bit register with increment and load, increment has priority, asynchronous active-low reset. The FSM stays in the top module.

Test Plan:
- Reset release, ROM[0..2] = 8'h12, 8'h34, 8'hF0, start = 1, step_mode = 0:
  - instr_valid pulses with opcode/operand 1/2, then 3/4, then F/0
  - halted = 1 after the third DECODE; pc_shadow = 2
  - pc_en pulsed exactly twice
- step_mode = 1, single start pulse at PC 0:
  - exactly one fetch_en, one instr_valid and one pc_en
  - returns to IDLE with pc_shadow = 1 and busy = 0
- jump_req = 1 with jump_addr = 12'h7FE during DECODE:
  - ADVANCE has pc_load = 1, pc_en = 0, pc_load_val = 12'h7FE
  - the next fetch reads ROM[12'h7FE]
- PC at 12'hFFF with a non-HALT instruction:
  - after ADVANCE, pc_shadow = 0 and the next fetch reads ROM[0]
- reset driven low during ADVANCE:
  - outputs go to 0 within the same cycle, with no pc_en edge
  - after release the state is IDLE and pc_shadow = 0
- FETCH_BKPT_EN, bkpt_addr = 3, bkpt_arm = 1, free run:
  - halted = 1 with pc_shadow = 3 and no fourth fetch_en
  - resume then start fetches ROM[3]

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg                                                        |
// | Shared state encoding and default widths for the fetch sequencer.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fetch_pkg;

  localparam int         DEFAULT_ADDR_W  = 12;
  localparam logic [3:0] DEFAULT_HALT_OP = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    ADVANCE = 3'd3,
    HALT    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_sequencer_if                                               |
// | Host/datapath bundle around the fetch sequencer.                 |
// | Optional FETCH_BKPT_EN adds bkpt_addr / bkpt_arm.                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fetch_sequencer_if #(
  parameter int ADDR_W = fetch_pkg::DEFAULT_ADDR_W
);
  logic              start;
  logic              step_mode;
  logic              resume;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_addr;
  logic [3:0]        opcode;
  logic [3:0]        operand;
  logic              pc_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              fetch_en;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_shadow;
  logic              busy;
  logic              halted;
`ifdef FETCH_BKPT_EN
  logic [ADDR_W-1:0] bkpt_addr;
  logic              bkpt_arm;

  modport master (
    output start, step_mode, resume, jump_req, jump_addr, opcode, operand,
           bkpt_addr, bkpt_arm,
    input  pc_en, pc_load, pc_load_val, fetch_en, instr_valid, pc_shadow,
           busy, halted
  );
  // operand is carried beside opcode for the host and is never decoded
  modport slave (
    input  start, step_mode, resume, jump_req, jump_addr, opcode,
           bkpt_addr, bkpt_arm,
    output pc_en, pc_load, pc_load_val, fetch_en, instr_valid, pc_shadow,
           busy, halted
  );
`else
  modport master (
    output start, step_mode, resume, jump_req, jump_addr, opcode, operand,
    input  pc_en, pc_load, pc_load_val, fetch_en, instr_valid, pc_shadow,
           busy, halted
  );
  modport slave (
    input  start, step_mode, resume, jump_req, jump_addr, opcode,
    output pc_en, pc_load, pc_load_val, fetch_en, instr_valid, pc_shadow,
           busy, halted
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pc_shadow_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_shadow_reg                                                    |
// | PC copy with increment and load; increment wins, like the counter|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pc_shadow_reg #(
  parameter int WIDTH = fetch_pkg::DEFAULT_ADDR_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc_i,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  output logic      [WIDTH-1:0] pc_o
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc_i) begin
      pc_d = pc_q + WIDTH'(1);
    end else if (load_i) begin
      pc_d = load_val_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_sequencer                                                  |
// | FETCH -> DECODE -> ADVANCE control for the PC/ROM/fetch datapath.|
// | Optional breakpoint on FETCH entry: define FETCH_BKPT_EN.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [3:0] HALT_OP = DEFAULT_HALT_OP,
  parameter int         ADDR_W  = DEFAULT_ADDR_W
) (
  input wire logic         Clk,
  input wire logic         reset,
  fetch_sequencer_if.slave bus
);
  state_t            state_q, state_d;
  logic              fetch_en_q, fetch_en_d;
  logic              instr_valid_q, instr_valid_d;
  logic              pc_en_q, pc_en_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_load_val_q, pc_load_val_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              advance_d;
  logic [ADDR_W-1:0] pc_q;
`ifdef FETCH_BKPT_EN
  logic              bkpt_skip_q, bkpt_skip_d;
  logic              bkpt_hit;
  logic [ADDR_W-1:0] pc_next;

  // PC value the next FETCH would present, after this cycle's strobe lands
  always_comb begin
    pc_next = pc_q;
    if (pc_en_q) begin
      pc_next = pc_q + ADDR_W'(1);
    end else if (pc_load_q) begin
      pc_next = pc_load_val_q;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    pc_load_val_d = pc_load_val_q;
`ifdef FETCH_BKPT_EN
    bkpt_skip_d   = bkpt_skip_q;
    bkpt_hit      = 1'b0;
`endif
    case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (bus.opcode == HALT_OP) ? HALT : ADVANCE;
      ADVANCE: state_d = bus.step_mode ? IDLE : FETCH;
      HALT:    if (bus.resume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FETCH_BKPT_EN
    if (state_d == FETCH) begin
      bkpt_hit    = bus.bkpt_arm && (pc_next == bus.bkpt_addr) && !bkpt_skip_q;
      bkpt_skip_d = bkpt_hit;
      if (bkpt_hit) state_d = HALT;
    end
`endif
    // Outputs are registered, so they are decoded from the state being entered
    advance_d     = (state_q == DECODE) && (state_d == ADVANCE);
    pc_en_d       = advance_d && !bus.jump_req;
    pc_load_d     = advance_d && bus.jump_req;
    if (pc_load_d) pc_load_val_d = bus.jump_addr;
    fetch_en_d    = (state_d == FETCH);
    instr_valid_d = (state_d == DECODE);
    busy_d        = (state_d != IDLE) && (state_d != HALT);
    halted_d      = (state_d == HALT);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_en_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_en_q       <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
`ifdef FETCH_BKPT_EN
      bkpt_skip_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_en_q    <= fetch_en_d;
      instr_valid_q <= instr_valid_d;
      pc_en_q       <= pc_en_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
`ifdef FETCH_BKPT_EN
      bkpt_skip_q   <= bkpt_skip_d;
`endif
    end
  end

  pc_shadow_reg #(.WIDTH(ADDR_W)) u_pc_shadow (
    .clk        (Clk),
    .rst_n      (reset),
    .inc_i      (pc_en_q),
    .load_i     (pc_load_q),
    .load_val_i (pc_load_val_q),
    .pc_o       (pc_q)
  );

  assign bus.pc_en       = pc_en_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_load_val = pc_load_val_q;
  assign bus.fetch_en    = fetch_en_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_shadow   = pc_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_sequencer                                               |
// | Self-checking bench: slot-level model plus directed scenarios.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fetch_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(12)) bus();
  fetch_sequencer dut (.Clk(clk), .reset(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Program ROM, PC counter and fetch register of the surrounding datapath
  logic [7:0]  rom [4096];
  logic [11:0] ctr;
  logic [7:0]  freg;
  assign bus.opcode  = freg[7:4];
  assign bus.operand = freg[3:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr  <= '0;
      freg <= '0;
    end else begin
      if (bus.pc_en) ctr <= ctr + 12'd1;
      else if (bus.pc_load) ctr <= bus.pc_load_val;
      if (bus.fetch_en) freg <= rom[ctr];
    end
  end

  int pe_edges = 0;
  always @(posedge clk) if (bus.pc_en === 1'b1) pe_edges++;

  // Model: mode 0 idle / 1 running / 2 halted; slot = cycle within the instruction
  int m_mode = 0, m_slot = 0, m_pc = 0, m_loadval = 0;
  bit m_jmp = 1'b0;
`ifdef FETCH_BKPT_EN
  bit m_skip = 1'b0;
`endif

  function automatic void enter_fetch();
    m_mode = 1;
    m_slot = 0;
`ifdef FETCH_BKPT_EN
    if (bus.bkpt_arm && m_pc == int'(bus.bkpt_addr) && !m_skip) begin
      m_mode = 2;
      m_skip = 1'b1;
    end else begin
      m_skip = 1'b0;
    end
`endif
  endfunction

  always @(negedge rst_n) begin
    m_mode = 0; m_slot = 0; m_pc = 0; m_loadval = 0; m_jmp = 1'b0;
`ifdef FETCH_BKPT_EN
    m_skip = 1'b0;
`endif
  end

  always @(posedge clk) begin
    if (rst_n) begin
      case (m_mode)
        0: if (bus.start) enter_fetch();
        1: begin
          if (m_slot == 0) begin
            m_slot = 1;
          end else if (m_slot == 1) begin
            if (bus.opcode == 4'hF) begin
              m_mode = 2;
            end else begin
              m_jmp = bus.jump_req;
              if (bus.jump_req) m_loadval = int'(bus.jump_addr);
              m_slot = 2;
            end
          end else begin
            m_pc = m_jmp ? m_loadval : (m_pc + 1) % 4096;
            if (bus.step_mode) m_mode = 0;
            else enter_fetch();
          end
        end
        default: if (bus.resume) m_mode = 0;
      endcase
    end
  end

  int fe_cnt = 0, iv_cnt = 0, pe_cnt = 0;
  logic [7:0]  ops [$];
  logic [11:0] ld_val = '0;
  logic        ld_en  = 1'b0;

  always @(negedge clk) begin
    bit run;
    run = (m_mode == 1);
    chk("busy",        32'(bus.busy),        32'(run));
    chk("halted",      32'(bus.halted),      32'(m_mode == 2));
    chk("fetch_en",    32'(bus.fetch_en),    32'(run && m_slot == 0));
    chk("instr_valid", 32'(bus.instr_valid), 32'(run && m_slot == 1));
    chk("pc_en",       32'(bus.pc_en),       32'(run && m_slot == 2 && !m_jmp));
    chk("pc_load",     32'(bus.pc_load),     32'(run && m_slot == 2 && m_jmp));
    chk("pc_load_val", 32'(bus.pc_load_val), 32'(m_loadval));
    chk("pc_shadow",   32'(bus.pc_shadow),   32'(m_pc));
    if (run && m_slot == 1) chk("fetched_instr", 32'({bus.opcode, bus.operand}), 32'(rom[m_pc]));
    if (bus.fetch_en) fe_cnt++;
    if (bus.pc_en) pe_cnt++;
    if (bus.instr_valid) begin
      iv_cnt++;
      ops.push_back({bus.opcode, bus.operand});
    end
    if (bus.pc_load) begin
      ld_val = bus.pc_load_val;
      ld_en  = bus.pc_en;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_halt(input int budget, input string nm);
    for (int k = 0; k < budget && !bus.halted; k++) cyc(1);
    chk(nm, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    int n, f0, i0, p0, e0;
    bus.start = 1'b0; bus.step_mode = 1'b0; bus.resume = 1'b0;
    bus.jump_req = 1'b0; bus.jump_addr = '0;
`ifdef FETCH_BKPT_EN
    bus.bkpt_addr = '0; bus.bkpt_arm = 1'b0;
`endif
    for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_pc",    32'(bus.pc_shadow), 32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_halt",  32'(bus.halted),    32'd0);
    chk("rst_fetch", 32'(bus.fetch_en),  32'd0);

    // Free run into a HALT opcode
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hF0;
    n = ops.size(); i0 = iv_cnt; p0 = pe_cnt;
    bus.start = 1'b1;
    wait_halt(30, "run_halted");
    bus.start = 1'b0;
    chk("run_iv_count", 32'(iv_cnt - i0), 32'd3);
    chk("run_op0",      32'(ops[n]),      32'h12);
    chk("run_op1",      32'(ops[n+1]),    32'h34);
    chk("run_op2",      32'(ops[n+2]),    32'hF0);
    chk("run_pc",       32'(bus.pc_shadow), 32'd2);
    chk("run_pe_count", 32'(pe_cnt - p0), 32'd2);
    bus.start = 1'b1;
    cyc(3);
    bus.start = 1'b0;
    chk("halt_ignores_start", 32'(bus.halted), 32'd1);
    bus.resume = 1'b1;
    cyc(1);
    bus.resume = 1'b0;
    cyc(1);
    chk("resume_idle", 32'({bus.halted, bus.busy}), 32'd0);

    // Single step from PC 0
    do_reset();
    bus.step_mode = 1'b1;
    f0 = fe_cnt; i0 = iv_cnt; p0 = pe_cnt;
    start_pulse();
    cyc(4);
    chk("step_fe",   32'(fe_cnt - f0), 32'd1);
    chk("step_iv",   32'(iv_cnt - i0), 32'd1);
    chk("step_pe",   32'(pe_cnt - p0), 32'd1);
    chk("step_pc",   32'(bus.pc_shadow), 32'd1);
    chk("step_busy", 32'(bus.busy), 32'd0);

    // Host jump to 12'h7FE
    bus.jump_req = 1'b1; bus.jump_addr = 12'h7FE;
    start_pulse();
    cyc(4);
    bus.jump_req = 1'b0;
    chk("jmp_load_val", 32'(ld_val), 32'h7FE);
    chk("jmp_no_en",    32'(ld_en),  32'd0);
    chk("jmp_pc",       32'(bus.pc_shadow), 32'h7FE);
    rom[12'h7FE] = 8'h56;
    n = ops.size();
    start_pulse();
    cyc(4);
    chk("jmp_fetch", 32'(ops[n]), 32'h56);
    chk("jmp_pc2",   32'(bus.pc_shadow), 32'h7FF);

    // Wrap from 12'hFFF to 0
    rom[12'h7FF] = 8'h21;
    bus.jump_req = 1'b1; bus.jump_addr = 12'hFFF;
    start_pulse();
    cyc(4);
    bus.jump_req = 1'b0;
    chk("wrap_pre_pc", 32'(bus.pc_shadow), 32'hFFF);
    rom[12'hFFF] = 8'h43;
    n = ops.size();
    start_pulse();
    cyc(4);
    chk("wrap_fetch", 32'(ops[n]), 32'h43);
    chk("wrap_pc",    32'(bus.pc_shadow), 32'd0);
    n = ops.size();
    start_pulse();
    cyc(4);
    chk("wrap_rom0", 32'(ops[n]), 32'h12);
    chk("wrap_pc1",  32'(bus.pc_shadow), 32'd1);

    // Reset asserted in the middle of ADVANCE
    bus.step_mode = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (bus.pc_en) break;
    end
    bus.start = 1'b0;
    chk("rst_adv_reached", 32'(bus.pc_en), 32'd1);
    e0 = pe_edges;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pe",   32'(bus.pc_en),       32'd0);
    chk("rst_async_busy", 32'(bus.busy),        32'd0);
    chk("rst_async_fe",   32'(bus.fetch_en),    32'd0);
    chk("rst_async_iv",   32'(bus.instr_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_no_pe_edge", 32'(pe_edges), 32'(e0));
    rst_n = 1'b1;
    cyc(1);
    chk("rst_rel_pc",   32'(bus.pc_shadow), 32'd0);
    chk("rst_rel_busy", 32'(bus.busy),      32'd0);
    chk("rst_rel_halt", 32'(bus.halted),    32'd0);

`ifdef FETCH_BKPT_EN
    // Breakpoint at PC 3, then resume and fetch through it
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78; rom[4] = 8'hF0;
    bus.bkpt_addr = 12'd3; bus.bkpt_arm = 1'b1;
    do_reset();
    f0 = fe_cnt;
    bus.start = 1'b1;
    wait_halt(40, "bkpt_halted");
    bus.start = 1'b0;
    chk("bkpt_pc", 32'(bus.pc_shadow), 32'd3);
    chk("bkpt_fe", 32'(fe_cnt - f0),   32'd3);
    bus.resume = 1'b1;
    cyc(1);
    bus.resume = 1'b0;
    cyc(1);
    n = ops.size();
    bus.start = 1'b1;
    wait_halt(40, "bkpt_resume_halted");
    bus.start = 1'b0;
    chk("bkpt_fetch3", 32'(ops[n]), 32'h78);
    chk("bkpt_pc4",    32'(bus.pc_shadow), 32'd4);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
